// File: rtl/instruction_fetch.sv
`default_nettype none
// instruction_fetch: single-issue fetch stage with a 1-cycle combinational-ROM fetch,
// stall hold, branch redirect with one bubble, and a saturating fetch counter.
module instruction_fetch #(
   parameter logic [15:0] RESET_ADDR = 16'd0,
   parameter logic [27:0] NOP_WORD   = 28'd0
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        iEnable,
   input  logic        iStall,
   input  logic        iBranchTaken,
   input  logic [7:0]  iBranchTarget,
   input  logic [27:0] iInstruction,
   output logic [15:0] oAddress,
   output logic [27:0] oInstruction,
   output logic [15:0] oPC,
   output logic        oValid,
   output logic [15:0] oFetchCount
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      BUBBLE = 2'b10
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] pc;
   logic [27:0] instr_q;
   logic [15:0] pc_q;
   logic        valid_q;
   logic [15:0] fetch_count;

   logic        do_fetch;
   logic        do_branch;
   logic        drop_valid;

   // Branch beats stall and enable in RUN; BUBBLE fetches unconditionally.
   always_comb begin
      state_next = state;
      do_fetch   = 1'b0;
      do_branch  = 1'b0;
      drop_valid = 1'b0;
      case (state)
         IDLE: begin
            if (iEnable) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (iBranchTaken) begin
               do_branch  = 1'b1;
               state_next = BUBBLE;
            end else if (!iEnable) begin
               drop_valid = 1'b1;
               state_next = IDLE;
            end else if (!iStall) begin
               do_fetch = 1'b1;
            end
         end
         BUBBLE: begin
            do_fetch   = 1'b1;
            state_next = RUN;
         end
         default: begin
            drop_valid = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= IDLE;
         pc          <= RESET_ADDR;
         instr_q     <= NOP_WORD;
         pc_q        <= RESET_ADDR;
         valid_q     <= 1'b0;
         fetch_count <= 16'd0;
      end else begin
         state <= state_next;
         if (do_branch) begin
            pc      <= {8'h00, iBranchTarget};
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
         end else if (do_fetch) begin
            instr_q <= iInstruction;
            pc_q    <= pc;
            pc      <= pc + 16'd1;
            valid_q <= 1'b1;
            if (fetch_count != 16'hFFFF) begin
               fetch_count <= fetch_count + 16'd1;
            end
         end else if (drop_valid) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign oAddress     = pc;
   assign oInstruction = instr_q;
   assign oPC          = pc_q;
   assign oValid       = valid_q;
   assign oFetchCount  = fetch_count;

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 16'd0, meaning the program counter value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 28'd0, meaning the bubble word placed in the instruction register.
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port iEnable  input  1  allows fetching to begin or continue; low freezes the fetch.
REQ-006 SHALL have port iStall  input  1  downstream not ready; hold the current instruction.
REQ-007 SHALL have port iBranchTaken  input  1  redirect the fetch in this cycle.
REQ-008 SHALL have port iBranchTarget  input  8  branch/jump target, taken from instruction bits [23:16].
REQ-009 SHALL have port iInstruction  input  28  word returned by the combinational ROM for oAddress.
REQ-010 SHALL have port oAddress  output  16  ROM address, equal to the current PC.
REQ-011 SHALL have port oInstruction  output  28  registered instruction presented to decode.
REQ-012 SHALL have port oPC  output  16  address from which oInstruction was fetched.
REQ-013 SHALL have port oValid  output  1  oInstruction is a real fetched word, not a bubble.
REQ-014 SHALL have port oFetchCount  output  16  count of valid fetches since reset, saturating.

Function
REQ-015 SHALL drive oAddress combinationally from the PC register, so the ROM word is captured at the next edge (1-cycle fetch latency).
REQ-016 SHALL implement states IDLE, RUN, BUBBLE, encoded in 2 bits; the unused code SHALL return to IDLE.
REQ-017 IDLE: oValid=0, PC held; iEnable=1 SHALL move to RUN with no capture in that same edge.
REQ-018 RUN, with iEnable=1, iStall=0 and iBranchTaken=0: at the edge SHALL set oInstruction<=iInstruction, oPC<=PC, PC<=PC+1, oValid<=1, and oFetchCount+=1.
REQ-019 RUN, with iStall=1 and iBranchTaken=0: SHALL hold PC, oInstruction, oPC, oValid and oFetchCount.
REQ-020 RUN, with iEnable=0: SHALL go to IDLE, hold PC and oInstruction, and clear oValid.
REQ-021 iBranchTaken=1 in RUN SHALL have priority over iStall and iEnable, and SHALL set PC<={8'h00,iBranchTarget}, oInstruction<=NOP_WORD and oValid<=0, and move to BUBBLE.
REQ-022 BUBBLE SHALL last exactly one cycle: it SHALL perform the normal fetch of REQ-018 from the target PC, ignore iStall and iBranchTaken, and return to RUN.
REQ-023 PC increment SHALL be 16-bit unsigned and SHALL wrap 16'hFFFF to 16'h0000 with no flag.
REQ-024 oFetchCount SHALL saturate at 16'hFFFF and SHALL not wrap.
REQ-025 A branch target equal to the current PC SHALL be legal and SHALL re-fetch the same address after one bubble.
REQ-026 Outputs other than oAddress SHALL be registered; no combinational path SHALL run from iInstruction to any output.

Reset
REQ-027 Reset=1 at an edge SHALL set PC=RESET_ADDR, oInstruction=NOP_WORD, oPC=RESET_ADDR, oValid=0, oFetchCount=0 and state IDLE, overriding all other inputs.
REQ-028 Reset asserted mid-fetch, during a stall or in BUBBLE SHALL take effect at that edge, and no partial capture SHALL occur.
REQ-029 After Reset deasserts, the first valid instruction SHALL appear no earlier than 2 edges after iEnable=1: one edge to enter RUN, one edge to capture.

Verification
REQ-030 Reset, then iEnable=1 with the ROM returning word=addr: oValid SHALL rise 2 edges later, and oPC/oInstruction SHALL step 0,1,2,3 with oFetchCount 1,2,3,4.
REQ-031 Stall: iStall=1 for 3 cycles at PC=5 -> oAddress SHALL stay 5, oInstruction SHALL be held, oFetchCount SHALL be unchanged, and fetching SHALL resume at 5.
REQ-032 Branch with iBranchTaken=1 and iBranchTarget=8 while PC=10 and iStall=1 -> next cycle SHALL show oValid=0, oInstruction=NOP_WORD, oAddress=8; the following cycle SHALL show oPC=8, oValid=1.
REQ-033 Wrap: PC forced to 16'hFFFF by sequence -> the fetch at FFFF SHALL be followed by oAddress=0000, and oFetchCount at FFFF SHALL stay FFFF on further fetches.
REQ-034 Reset pulsed for one cycle while in BUBBLE -> the next cycle SHALL show oValid=0, oAddress=RESET_ADDR, state IDLE, oFetchCount=0.
REQ-035 iEnable dropped in RUN at PC=3 -> oValid SHALL be 0 and PC SHALL hold 3; iEnable re-raised SHALL give the first valid oPC=3 after 2 edges.
